// File: rtl/led_blink_scheduler.sv
// led_blink_scheduler
// Shares one board status LED among four requesters. A round-robin arbiter
// picks one eligible requester (req set, non-zero pulse count); a tick-timed
// phase machine then plays N ON/OFF pulses followed by an inter-code gap,
// and hands a one-cycle done pulse back to the granted requester.
// The board clock is nominally 27 MHz; TICK_DIV sets the tick period in
// clock cycles (default 100 ms at 27 MHz).
// Optional build macro: LED_ACTIVE_LOW_EN -- when defined, IO_voltage is
// driven active-low (1 = dark). Timing and all other outputs are unchanged.
module led_blink_scheduler #(
    parameter int unsigned TICK_DIV  = 2_700_000,
    parameter int unsigned ON_TICKS  = 2,
    parameter int unsigned OFF_TICKS = 3,
    parameter int unsigned GAP_TICKS = 10
) (
    input  logic        Clock,
    input  logic        Reset_n,
    input  logic [3:0]  req,
    input  logic [15:0] pulse_cnt,
    output logic [3:0]  grant,
    output logic [3:0]  done,
    output logic        busy,
    output logic        IO_voltage
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ON   = 2'd1;
    localparam logic [1:0] ST_OFF  = 2'd2;
    localparam logic [1:0] ST_GAP  = 2'd3;

    localparam logic [23:0] PRESC_LAST = 24'(TICK_DIV - 1);
    localparam logic [7:0]  ON_LAST    = 8'(ON_TICKS - 1);
    localparam logic [7:0]  OFF_LAST   = 8'(OFF_TICKS - 1);
    localparam logic [7:0]  GAP_LAST   = 8'(GAP_TICKS - 1);

`ifdef LED_ACTIVE_LOW_EN
    localparam logic LED_LIT  = 1'b0;
    localparam logic LED_DARK = 1'b1;
`else
    localparam logic LED_LIT  = 1'b1;
    localparam logic LED_DARK = 1'b0;
`endif

    logic [1:0]  state_q, state_d;
    logic [23:0] presc_q, presc_d;
    logic [7:0]  phase_q, phase_d;
    logic [3:0]  rem_q,   rem_d;
    logic [1:0]  last_q,  last_d;
    logic [3:0]  grant_q, grant_d;
    logic [3:0]  done_q,  done_d;
    logic        busy_q,  busy_d;
    logic        led_q,   led_d;

    logic [3:0]  elig;
    logic        found;
    logic [1:0]  win;
    logic [1:0]  idx;
    logic        tick;
    logic [7:0]  phase_last;
    logic        phase_end;

    // Requester is eligible only with a live request and a non-zero code length
    always_comb begin
        elig = '0;
        for (int i = 0; i < 4; i++) begin
            elig[i] = req[i] && (pulse_cnt[4*i +: 4] != 4'd0);
        end
    end

    // Round-robin search starting just after the last winner, ending on it
    always_comb begin
        found = 1'b0;
        win   = last_q;
        idx   = last_q;
        for (int k = 1; k <= 4; k++) begin
            idx = last_q + 2'(k);
            if (!found && elig[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    // Tick strobe and end-of-phase detection for the current state
    always_comb begin
        tick = (state_q != ST_IDLE) && (presc_q == PRESC_LAST);
        case (state_q)
            ST_ON:   phase_last = ON_LAST;
            ST_OFF:  phase_last = OFF_LAST;
            ST_GAP:  phase_last = GAP_LAST;
            default: phase_last = 8'd0;
        endcase
        phase_end = tick && (phase_q == phase_last);
    end

    // Next-state logic: arbitration in IDLE, timed pulse playback otherwise
    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        phase_d = phase_q;
        rem_d   = rem_q;
        last_d  = last_q;
        grant_d = grant_q;
        done_d  = '0;
        busy_d  = busy_q;
        led_d   = led_q;

        if (state_q == ST_IDLE) begin
            presc_d = '0;
            phase_d = '0;
            if (found) begin
                state_d = ST_ON;
                grant_d = 4'b0001 << win;
                last_d  = win;
                rem_d   = pulse_cnt[4*win +: 4];
                busy_d  = 1'b1;
                led_d   = LED_LIT;
            end
        end else begin
            presc_d = tick ? '0 : presc_q + 24'd1;
            phase_d = tick ? phase_q + 8'd1 : phase_q;
            if (phase_end) begin
                presc_d = '0;
                phase_d = '0;
                case (state_q)
                    ST_ON: begin
                        rem_d = rem_q - 4'd1;
                        led_d = LED_DARK;
                        // Last pulse goes straight into the gap, no OFF phase
                        state_d = (rem_q == 4'd1) ? ST_GAP : ST_OFF;
                    end
                    ST_OFF: begin
                        state_d = ST_ON;
                        led_d   = LED_LIT;
                    end
                    default: begin
                        state_d = ST_IDLE;
                        grant_d = '0;
                        busy_d  = 1'b0;
                        done_d  = grant_q;
                    end
                endcase
            end
        end
    end

    // State registers; reset aborts any playback and darkens the LED at once
    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            state_q <= ST_IDLE;
            presc_q <= '0;
            phase_q <= '0;
            rem_q   <= '0;
            last_q  <= 2'd3;
            grant_q <= '0;
            done_q  <= '0;
            busy_q  <= 1'b0;
            led_q   <= LED_DARK;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            phase_q <= phase_d;
            rem_q   <= rem_d;
            last_q  <= last_d;
            grant_q <= grant_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            led_q   <= led_d;
        end
    end

    assign grant      = grant_q;
    assign done       = done_q;
    assign busy       = busy_q;
    assign IO_voltage = led_q;

endmodule

// File: tb/tb_led_blink_scheduler.sv
// Testbench for led_blink_scheduler: directed scenarios feed a scoreboard of
// expected playbacks; a negedge monitor records each grant's LED waveform
// and compares it against the popped expectation when done pulses.
module tb_led_blink_scheduler;

    localparam int TD   = 4;
    localparam int ONT  = 1;
    localparam int OFFT = 1;
    localparam int GAPT = 2;

`ifdef LED_ACTIVE_LOW_EN
    localparam logic LED_INV = 1'b1;
`else
    localparam logic LED_INV = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req;
    logic [15:0] pulse_cnt;
    logic [3:0]  grant;
    logic [3:0]  done;
    logic        busy;
    logic        io_v;

    always #5 clk = ~clk;

    led_blink_scheduler #(
        .TICK_DIV (TD),
        .ON_TICKS (ONT),
        .OFF_TICKS(OFFT),
        .GAP_TICKS(GAPT)
    ) dut (
        .Clock     (clk),
        .Reset_n   (rst_n),
        .req       (req),
        .pulse_cnt (pulse_cnt),
        .grant     (grant),
        .done      (done),
        .busy      (busy),
        .IO_voltage(io_v)
    );

    typedef struct {
        logic [3:0]   grant;
        int           len;
        logic [127:0] pat;
        int           gap;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    // Expected playback: N lit ON phases separated by dark OFF phases, then a dark gap
    function automatic exp_t make_exp(logic [3:0] g, int n, int gap);
        exp_t e;
        e.grant = g;
        e.gap   = gap;
        e.pat   = '0;
        e.len   = 0;
        for (int p = 0; p < n; p++) begin
            for (int c = 0; c < ONT * TD; c++) begin
                e.pat = {e.pat[126:0], 1'b1};
                e.len++;
            end
            if (p < n - 1) begin
                for (int c = 0; c < OFFT * TD; c++) begin
                    e.pat = {e.pat[126:0], 1'b0};
                    e.len++;
                end
            end
        end
        for (int c = 0; c < GAPT * TD; c++) begin
            e.pat = {e.pat[126:0], 1'b0};
            e.len++;
        end
        return e;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Monitor: record each grant's LED waveform and score it on done
    logic [3:0]   prev_grant = '0;
    logic [3:0]   cur_grant  = '0;
    int           len        = 0;
    int           low_run    = 1000;
    int           gap_before = 0;
    logic [127:0] pat        = '0;
    logic         led_n;
    exp_t         e_mon;

    always @(negedge clk) begin
        led_n = io_v ^ LED_INV;
        check("busy_vs_grant", {127'd0, busy}, {127'd0, |grant});
        if (grant == 4'd0) check("led_dark_when_idle", {127'd0, led_n}, 128'd0);
        else               check("grant_onehot", {127'd0, $onehot(grant)}, 128'd1);
        if (grant != 4'd0 && prev_grant == 4'd0) begin
            cur_grant  = grant;
            len        = 0;
            pat        = '0;
            gap_before = low_run;
        end
        if (grant != 4'd0) begin
            len++;
            pat     = {pat[126:0], led_n};
            low_run = 0;
        end else begin
            low_run++;
        end
        if (done != 4'd0) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done actual=%b required=none", done);
            end else begin
                e_mon = sb_q.pop_front();
                check("done_vector", {124'd0, done}, {124'd0, e_mon.grant});
                check("granted_requester", {124'd0, cur_grant}, {124'd0, e_mon.grant});
                check("done_on_grant_fall", {124'd0, prev_grant, grant}, {124'd0, e_mon.grant, 4'd0});
                check("grant_length", 128'(len), 128'(e_mon.len));
                check("led_waveform", pat, e_mon.pat);
                if (e_mon.gap >= 0) check("idle_gap_before_grant", 128'(gap_before), 128'(e_mon.gap));
            end
        end
        prev_grant = grant;
    end

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req   = '0;
        @(negedge clk);
        check("reset_grant", {124'd0, grant}, 128'd0);
        check("reset_done", {124'd0, done}, 128'd0);
        check("reset_busy", {127'd0, busy}, 128'd0);
        check("reset_led", {127'd0, io_v}, {127'd0, LED_INV});
        rst_n = 1'b1;
    endtask

    task automatic wait_drain(input int budget);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            #1;
            if (sb_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout actual=%0d pending required=0", sb_q.size());
        end
    endtask

    task automatic wait_grant(input logic [3:0] g, input int budget, input string name);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (grant == g) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL %s actual=%b required=%b", name, grant, g);
        end
    endtask

    logic seen;

    initial begin
        rst_n     = 1'b0;
        req       = '0;
        pulse_cnt = '0;

        // Scenario 1: single requester, two pulses, one-cycle grant latency
        apply_reset();
        pulse_cnt = 16'h0002;
        req       = 4'b0001;
        sb_q.push_back(make_exp(4'b0001, 2, -1));
        @(negedge clk);
        check("grant_latency", {124'd0, grant}, 128'd1);
        check("first_on_lit", {127'd0, io_v ^ LED_INV}, 128'd1);
        req = '0;
        wait_drain(100);

        // Scenario 2: all four requesting, round-robin 0,1,2,3,0
        apply_reset();
        pulse_cnt = 16'h1111;
        req       = 4'b1111;
        sb_q.push_back(make_exp(4'b0001, 1, -1));
        sb_q.push_back(make_exp(4'b0010, 1, 1));
        sb_q.push_back(make_exp(4'b0100, 1, 1));
        sb_q.push_back(make_exp(4'b1000, 1, 1));
        sb_q.push_back(make_exp(4'b0001, 1, 1));
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (sb_q.size() == 1 && grant == 4'b0001) begin
                seen = 1'b1;
                break;
            end
        end
        check("rr_wraps_to_req0", {127'd0, seen}, 128'd1);
        req = '0;
        wait_drain(100);
        repeat (5) @(negedge clk);
        check("no_regrant_after_release", {124'd0, grant}, 128'd0);

        // Scenario 3: zero pulse count is never granted
        apply_reset();
        pulse_cnt = 16'h1011;
        req       = 4'b0100;
        seen      = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (grant != 4'd0 || busy || done != 4'd0 || ((io_v ^ LED_INV) != 1'b0)) seen = 1'b1;
        end
        check("zero_count_ignored", {127'd0, seen}, 128'd0);
        req = '0;

        // Scenario 4: request/count changes during playback are ignored
        apply_reset();
        pulse_cnt = 16'h0030;
        req       = 4'b0010;
        sb_q.push_back(make_exp(4'b0010, 3, -1));
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        pulse_cnt = 16'h0010;
        req       = '0;
        wait_drain(200);

        // Scenario 5: reset during second ON phase aborts, then priority restarts at 0
        apply_reset();
        pulse_cnt = 16'h0200;
        req       = 4'b0100;
        @(negedge clk);
        check("abort_grant_up", {124'd0, grant}, 128'h4);
        req = '0;
        repeat (9) @(negedge clk);
        check("second_on_lit", {127'd0, io_v ^ LED_INV}, 128'd1);
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_led", {127'd0, io_v}, {127'd0, LED_INV});
        check("abort_grant", {124'd0, grant}, 128'd0);
        check("abort_busy", {127'd0, busy}, 128'd0);
        check("abort_done", {124'd0, done}, 128'd0);
        rst_n     = 1'b1;
        pulse_cnt = 16'h0011;
        req       = 4'b0011;
        sb_q.push_back(make_exp(4'b0001, 1, -1));
        sb_q.push_back(make_exp(4'b0010, 1, 1));
        wait_grant(4'b0001, 10, "post_reset_first_grant");
        req = 4'b0010;
        wait_grant(4'b0010, 40, "post_reset_second_grant");
        req = '0;
        wait_drain(100);

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
